reg_bus_arbiter: RTL

- Shares one 32-bit register bank between two register-bus masters.
- Port 0 is the SPI slave's strobe interface (addr/data_out/wr_en/rd_en/data_in). Port 1 is a second master, e.g. the MCU/host bridge.
- Captures each master's single-cycle rd/wr strobes into a one-deep pending slot, arbitrates round-robin, and runs a strobe/ack transaction to the bank.
- Returns read data and completion pulses to the originating master.

---
 rtl/reg_bus_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter sharing one register bank between two strobe masters
// Optional ack timeout with sticky bus_err: define REG_ARB_TIMEOUT_EN.
module reg_bus_arbiter #(
    parameter int ASZ     = 7,
    parameter int DSZ     = 32,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [ASZ-1:0] req0_addr,
    input  logic [DSZ-1:0] req0_wdata,
    input  logic           req0_wr_en,
    input  logic           req0_rd_en,
    output logic [DSZ-1:0] req0_rdata,
    output logic           req0_rd_valid,
    output logic           req0_wr_done,
    output logic           req0_overrun,
    input  logic [ASZ-1:0] req1_addr,
    input  logic [DSZ-1:0] req1_wdata,
    input  logic           req1_wr_en,
    input  logic           req1_rd_en,
    output logic [DSZ-1:0] req1_rdata,
    output logic           req1_rd_valid,
    output logic           req1_wr_done,
    output logic           req1_overrun,
    output logic [ASZ-1:0] t_addr,
    output logic [DSZ-1:0] t_wdata,
    output logic           t_wr,
    output logic           t_rd,
    input  logic [DSZ-1:0] t_rdata,
    input  logic           t_ack,
    output logic           bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t         r_state;
    logic           r_gnt;
    logic           r_last;
    logic [1:0]     r_pend;
    logic [1:0]     r_slot_wr;
    logic [ASZ-1:0] r_slot_addr  [2];
    logic [DSZ-1:0] r_slot_wdata [2];
    logic [1:0]     r_ovr;
    logic [1:0]     r_rdv;
    logic [1:0]     r_wrd;
    logic [DSZ-1:0] r_rdata [2];
    logic [ASZ-1:0] r_t_addr;
    logic [DSZ-1:0] r_t_wdata;
    logic           r_t_wr;
    logic           r_t_rd;

    logic [1:0]     w_wr;
    logic [1:0]     w_rd;
    logic [ASZ-1:0] w_addr  [2];
    logic [DSZ-1:0] w_wdata [2];
    logic [1:0]     w_retire;
    logic           w_pick;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_LIMIT = CW'(TIMEOUT);
    localparam logic [DSZ-1:0] TO_RDATA = {(DSZ/2){2'b10}};
    logic [CW-1:0] r_cnt;
    logic          r_bus_err;
    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    assign w_wr       = {req1_wr_en, req0_wr_en};
    assign w_rd       = {req1_rd_en, req0_rd_en};
    assign w_addr[0]  = req0_addr;
    assign w_addr[1]  = req1_addr;
    assign w_wdata[0] = req0_wdata;
    assign w_wdata[1] = req1_wdata;

    // The granted slot frees up at the end of DONE, so a strobe landing then is kept.
    assign w_retire = (r_state == S_DONE) ? {r_gnt, ~r_gnt} : 2'b00;

    always_comb begin
        w_pick = r_pend[0] ? 1'b0 : 1'b1;
        if (r_pend == 2'b11) begin
            w_pick = ~r_last;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pend    <= 2'b00;
            r_slot_wr <= 2'b00;
            r_ovr     <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_slot_addr[n]  <= '0;
                r_slot_wdata[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_wr[n] || w_rd[n]) begin
                    if (r_pend[n] && !w_retire[n]) begin
                        r_ovr[n] <= 1'b1;
                    end else begin
                        r_pend[n]       <= 1'b1;
                        r_slot_wr[n]    <= w_wr[n];
                        r_slot_addr[n]  <= w_addr[n];
                        r_slot_wdata[n] <= w_wdata[n];
                    end
                end else if (w_retire[n]) begin
                    r_pend[n] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_rdv     <= 2'b00;
            r_wrd     <= 2'b00;
            r_rdata   <= '{default: '0};
            r_t_addr  <= '0;
            r_t_wdata <= '0;
            r_t_wr    <= 1'b0;
            r_t_rd    <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pend != 2'b00) begin
                        r_gnt     <= w_pick;
                        r_last    <= w_pick;
                        r_t_addr  <= r_slot_addr[w_pick];
                        r_t_wdata <= r_slot_wdata[w_pick];
                        r_t_wr    <= r_slot_wr[w_pick];
                        r_t_rd    <= ~r_slot_wr[w_pick];
                        r_state   <= S_ISSUE;
`ifdef REG_ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                S_ISSUE, S_WAIT: begin
                    r_t_wr <= 1'b0;
                    r_t_rd <= 1'b0;
                    if (t_ack) begin
                        r_state <= S_DONE;
                        if (r_slot_wr[r_gnt]) begin
                            r_wrd[r_gnt] <= 1'b1;
                        end else begin
                            r_rdv[r_gnt]   <= 1'b1;
                            r_rdata[r_gnt] <= t_rdata;
                        end
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (r_cnt == TO_LIMIT) begin
                        r_state   <= S_DONE;
                        r_bus_err <= 1'b1;
                        if (r_slot_wr[r_gnt]) begin
                            r_wrd[r_gnt] <= 1'b1;
                        end else begin
                            r_rdv[r_gnt]   <= 1'b1;
                            r_rdata[r_gnt] <= TO_RDATA;
                        end
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_WAIT;
                    end
`else
                    else begin
                        r_state <= S_WAIT;
                    end
`endif
                end
                S_DONE: begin
                    r_rdv   <= 2'b00;
                    r_wrd   <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_rdata    = r_rdata[0];
    assign req0_rd_valid = r_rdv[0];
    assign req0_wr_done  = r_wrd[0];
    assign req0_overrun  = r_ovr[0];
    assign req1_rdata    = r_rdata[1];
    assign req1_rd_valid = r_rdv[1];
    assign req1_wr_done  = r_wrd[1];
    assign req1_overrun  = r_ovr[1];
    assign t_addr        = r_t_addr;
    assign t_wdata       = r_t_wdata;
    assign t_wr          = r_t_wr;
    assign t_rd          = r_t_rd;

endmodule
